// File: rtl/vec_fixed_pkg.sv
// Shared fixed-point definitions for the lane-wise vector multiplier.
// Default Q16.16 format constants, lane slicing helper and mode encodings.
package vec_fixed_pkg;

   localparam int W_DEF    = 32;
   localparam int FRAC_DEF = 16;

   localparam logic [W_DEF-1:0] FIXED_MAX = {1'b0, {(W_DEF-1){1'b1}}};
   localparam logic [W_DEF-1:0] FIXED_MIN = {1'b1, {(W_DEF-1){1'b0}}};

   typedef enum logic {
      MODE_LANEWISE  = 1'b0,
      MODE_BROADCAST = 1'b1
   } mode_e;

   // lsb position of lane `lane` in a packed vector of `w`-bit lanes
   function automatic int lane_lsb(input int lane, input int w);
      return lane * w;
   endfunction

endpackage

// File: rtl/fixed_mul_lane_pipe.sv
// One signed W x W fixed-point lane with a stall-able LAT-stage pipeline.
// Saturation and the overflow flag exist only when VECTOR_MUL_LANES_SAT_EN is defined.
module fixed_mul_lane_pipe
   import vec_fixed_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int FRAC = FRAC_DEF,
   parameter int LAT  = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] res
`ifdef VECTOR_MUL_LANES_SAT_EN
   ,
   output logic         ovf
`endif
);

   logic signed [W-1:0]   a_q;
   logic signed [W-1:0]   b_q;
   logic signed [2*W-1:0] prod;
   logic signed [2*W-1:0] prod_last;
   logic signed [2*W-1:0] shifted;
   logic        [W-1:0]   res_d;

   always_ff @(posedge clk) begin
      if (en) begin
         a_q <= a;
         b_q <= b;
      end
   end

   assign prod = a_q * b_q;

   // product delay fills stages 1..LAT-2; with LAT=2 the result stage multiplies directly
   generate
      if (LAT > 2) begin : g_dly
         logic signed [2*W-1:0] dly [LAT-2];
         always_ff @(posedge clk) begin
            if (en) begin
               dly[0] <= prod;
               for (int k = 1; k < LAT-2; k++) dly[k] <= dly[k-1];
            end
         end
         assign prod_last = dly[LAT-3];
      end else begin : g_nodly
         assign prod_last = prod;
      end
   endgenerate

   assign shifted = prod_last >>> FRAC;

`ifdef VECTOR_MUL_LANES_SAT_EN
   localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
   logic in_range;

   always_comb begin
      in_range = (shifted[2*W-1:W-1] == '0) || (shifted[2*W-1:W-1] == '1);
      res_d    = shifted[W-1:0];
      if (!in_range) res_d = shifted[2*W-1] ? SAT_MIN : SAT_MAX;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res <= '0;
         ovf <= 1'b0;
      end else if (en) begin
         res <= res_d;
         ovf <= !in_range;
      end
   end
`else
   logic unused_hi;
   assign unused_hi = ^shifted[2*W-1:W];

   always_comb begin
      res_d = shifted[W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst)     res <= '0;
      else if (en) res <= res_d;
   end
`endif

endmodule

// File: rtl/vector_mul_lanes.sv
// Pipelined lane-wise fixed-point vector multiplier with valid/ready and scalar broadcast.
// Define VECTOR_MUL_LANES_SAT_EN for saturating lanes and the per-lane ovf output.
module vector_mul_lanes
   import vec_fixed_pkg::*;
#(
   parameter int LANES = 3,
   parameter int W     = W_DEF,
   parameter int FRAC  = FRAC_DEF,
   parameter int LAT   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               mode,
   input  logic [LANES*W-1:0] v1,
   input  logic [LANES*W-1:0] v2,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES*W-1:0] r
`ifdef VECTOR_MUL_LANES_SAT_EN
   ,
   output logic [LANES-1:0]   ovf
`endif
);

   logic [LAT-1:0] vld;
   logic           stall;

   assign out_valid = vld[LAT-1];
   assign stall     = out_valid && !out_ready;
   assign in_ready  = !stall;

   // the whole pipeline freezes on stall, bubbles included
   always_ff @(posedge clk) begin
      if (rst)         vld <= '0;
      else if (!stall) vld <= {vld[LAT-2:0], in_valid && in_ready};
   end

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         logic [W-1:0] b_sel;
         assign b_sel = (mode_e'(mode) == MODE_BROADCAST) ? v2[W-1:0]
                                                         : v2[lane_lsb(i, W) +: W];
         fixed_mul_lane_pipe #(
            .W    (W),
            .FRAC (FRAC),
            .LAT  (LAT)
         ) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (!stall),
            .a   (v1[lane_lsb(i, W) +: W]),
            .b   (b_sel),
            .res (r[lane_lsb(i, W) +: W])
`ifdef VECTOR_MUL_LANES_SAT_EN
            ,
            .ovf (ovf[i])
`endif
         );
      end
   endgenerate

endmodule

// File: tb/tb_vector_mul_lanes.sv
// Randomised and directed bench for vector_mul_lanes: default Q16.16 x3 instance plus a 4 x Q8.8 instance.
// Expected results come from a 64-bit integer reference model and per-instance scoreboard queues.
module tb_vector_mul_lanes;
   import vec_fixed_pkg::*;

   localparam int LAT = 4;
   localparam int LA = 3, WA = 32, FA = 16;
   localparam int LB = 4, WB = 16, FB = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic             a_in_valid = 1'b0, a_mode = 1'b0, a_out_ready = 1'b1;
   logic             a_in_ready, a_out_valid;
   logic [LA*WA-1:0] a_v1 = '0, a_v2 = '0, a_r;
   logic             b_in_valid = 1'b0, b_mode = 1'b0, b_out_ready = 1'b1;
   logic             b_in_ready, b_out_valid;
   logic [LB*WB-1:0] b_v1 = '0, b_v2 = '0, b_r;
`ifdef VECTOR_MUL_LANES_SAT_EN
   logic [LA-1:0]    a_ovf;
   logic [LB-1:0]    b_ovf;
`endif

   int n_cmp = 0, n_bad = 0;
   int ready_mode = 0;
   int a_rx = 0, b_rx = 0;
   logic [131:0] qa[$], qb[$];

   always #5 clk = ~clk;

   vector_mul_lanes #(.LANES(LA), .W(WA), .FRAC(FA), .LAT(LAT)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .mode(a_mode),
      .v1(a_v1), .v2(a_v2), .out_valid(a_out_valid), .out_ready(a_out_ready), .r(a_r)
`ifdef VECTOR_MUL_LANES_SAT_EN
      , .ovf(a_ovf)
`endif
   );

   vector_mul_lanes #(.LANES(LB), .W(WB), .FRAC(FB), .LAT(LAT)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .mode(b_mode),
      .v1(b_v1), .v2(b_v2), .out_valid(b_out_valid), .out_ready(b_out_ready), .r(b_r)
`ifdef VECTOR_MUL_LANES_SAT_EN
      , .ovf(b_ovf)
`endif
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // lane value = floor(a*b / 2^frac), then wrapped (or clamped when saturating)
   function automatic longint ref_mul(input longint a, input longint b, input int w,
                                      input int frac, output bit ov);
      longint s, mx, mn;
      s  = (a * b) >>> frac;
      mx = (longint'(1) <<< (w-1)) - 1;
      mn = -mx - 1;
      ov = (s > mx) || (s < mn);
`ifdef VECTOR_MUL_LANES_SAT_EN
      if (s > mx) s = mx;
      else if (s < mn) s = mn;
`endif
      return s;
   endfunction

   task automatic exp_vec(input logic [127:0] v1, input logic [127:0] v2, input logic m,
                          input int lanes, input int w, input int frac, output logic [131:0] e);
      longint x, y, s;
      bit ov;
      logic [127:0] mask;
      mask = (128'(1) << w) - 1;
      e = '0;
      for (int i = 0; i < lanes; i++) begin
         x = longint'(v1 >> (i*w));
         y = longint'(v2 >> ((m ? 0 : i)*w));
         x = (x <<< (64-w)) >>> (64-w);
         y = (y <<< (64-w)) >>> (64-w);
         s = ref_mul(x, y, w, frac, ov);
         e[127:0] = e[127:0] | ((128'(s) & mask) << (i*w));
         e[128+i] = ov;
      end
   endtask

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: begin a_out_ready = 1'b1; b_out_ready = 1'b1; end
         1: begin
            a_out_ready = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 3) != 0);
         end
         default: begin a_out_ready = 1'b0; b_out_ready = 1'b0; end
      endcase
   end

   bit          a_prev_stall = 1'b0;
   logic [95:0] a_prev_r;
   always @(negedge clk) begin
      logic [131:0] e;
      if (rst) begin
         qa.delete();
         a_prev_stall = 1'b0;
      end else begin
         chk("a_in_ready_rule", a_in_ready, !(a_out_valid && !a_out_ready));
         if (a_prev_stall) begin
            chk("a_hold_valid", a_out_valid, 1);
            chk("a_hold_r", a_r, a_prev_r);
         end
         if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) chk("a_stale", a_out_valid, 0);
            else begin
               e = qa.pop_front();
               chk("a_r", a_r, e[95:0]);
`ifdef VECTOR_MUL_LANES_SAT_EN
               chk("a_ovf", a_ovf, e[130:128]);
`endif
               a_rx++;
            end
         end
         if (a_in_valid && a_in_ready) begin
            exp_vec(a_v1, a_v2, a_mode, LA, WA, FA, e);
            qa.push_back(e);
         end
         a_prev_stall = a_out_valid && !a_out_ready;
         a_prev_r     = a_r;
      end
   end

   bit          b_prev_stall = 1'b0;
   logic [63:0] b_prev_r;
   always @(negedge clk) begin
      logic [131:0] e;
      if (rst) begin
         qb.delete();
         b_prev_stall = 1'b0;
      end else begin
         if (b_prev_stall) chk("b_hold_r", b_r, b_prev_r);
         if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) chk("b_stale", b_out_valid, 0);
            else begin
               e = qb.pop_front();
               chk("b_r", b_r, e[63:0]);
`ifdef VECTOR_MUL_LANES_SAT_EN
               chk("b_ovf", b_ovf, e[131:128]);
`endif
               b_rx++;
            end
         end
         if (b_in_valid && b_in_ready) begin
            exp_vec(b_v1, b_v2, b_mode, LB, WB, FB, e);
            qb.push_back(e);
         end
         b_prev_stall = b_out_valid && !b_out_ready;
         b_prev_r     = b_r;
      end
   end

   // called just after a posedge; returns just after the edge that took the beat
   task automatic send_a(input logic [95:0] v1, input logic [95:0] v2, input logic m);
      bit rs;
      int n = 0;
      a_v1 = v1; a_v2 = v2; a_mode = m; a_in_valid = 1'b1;
      do begin
         @(negedge clk); rs = a_in_ready;
         @(posedge clk); #1; n++;
      end while (!rs && n < 1000);
      if (!rs) chk("a_accept_timeout", a_in_ready, 1);
      a_in_valid = 1'b0;
   endtask

   task automatic send_b(input logic [63:0] v1, input logic [63:0] v2, input logic m);
      bit rs;
      int n = 0;
      b_v1 = v1; b_v2 = v2; b_mode = m; b_in_valid = 1'b1;
      do begin
         @(negedge clk); rs = b_in_ready;
         @(posedge clk); #1; n++;
      end while (!rs && n < 1000);
      if (!rs) chk("b_accept_timeout", b_in_ready, 1);
      b_in_valid = 1'b0;
   endtask

   // cycles from the accept cycle (1 = cycle after accept) until out_valid shows
   task automatic wait_lat(output int lat);
      lat = 1;
      while (!a_out_valid && lat < LAT + 10) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic drain(input bit sel_b);
      int n = 0;
      while ((sel_b ? qb.size() : qa.size()) != 0 && n < 300) begin
         @(posedge clk); #1; n++;
      end
      if (sel_b) chk("b_drain_left", qb.size(), 0);
      else       chk("a_drain_left", qa.size(), 0);
   endtask

   function automatic logic [95:0] rnd96();
      return {$urandom, $urandom, $urandom};
   endfunction

   initial begin
      int lat, base;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_r", a_r, 0);
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_b_out_valid", b_out_valid, 0);

      // lane-wise {2.0,-1.5,0.5} * {3.0,2.0,0.5}
      send_a({32'h00008000, 32'hFFFE8000, 32'h00020000},
             {32'h00008000, 32'h00020000, 32'h00030000}, MODE_LANEWISE);
      wait_lat(lat);
      chk("lanewise_latency", lat, LAT);
      chk("lanewise_r", a_r, {32'h00004000, 32'hFFFD0000, 32'h00060000});
      @(posedge clk); #1;

      // broadcast {1.0,2.0,-4.0} * 0.25
      send_a({32'hFFFC0000, 32'h00020000, 32'h00010000},
             {$urandom, $urandom, 32'h00004000}, MODE_BROADCAST);
      wait_lat(lat);
      chk("broadcast_latency", lat, LAT);
      chk("broadcast_r", a_r, {32'hFFFF0000, 32'h00008000, 32'h00004000});
      @(posedge clk); #1;

      // overflow positive and negative
      send_a({32'h00000000, 32'h80000000, 32'h7FFF0000},
             {32'h00000000, 32'h00020000, 32'h00020000}, MODE_LANEWISE);
      wait_lat(lat);
`ifdef VECTOR_MUL_LANES_SAT_EN
      chk("ovf_r", a_r, {32'h00000000, FIXED_MIN, FIXED_MAX});
      chk("ovf_flags", a_ovf, 3'b011);
`else
      chk("ovf_wrap_r", a_r, {32'h00000000, 32'h00000000, 32'hFFFE0000});
`endif
      @(posedge clk); #1;

      // backpressure: 8 back-to-back beats, consumer stalls 5 cycles mid-stream
      base = a_rx;
      fork
         for (int k = 0; k < 8; k++) send_a(rnd96(), rnd96(), logic'(k % 2));
         begin
            repeat (6) @(posedge clk);
            @(negedge clk) ready_mode = 2;
            for (int i = 0; i < 5; i++) begin
               @(posedge clk); #2;
               chk("bp_in_ready_low", a_in_ready, 0);
            end
            @(negedge clk) ready_mode = 0;
         end
      join
      drain(1'b0);
      chk("bp_result_count", a_rx - base, 8);

      // reset with beats in flight
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) send_a(rnd96(), rnd96(), MODE_LANEWISE);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk("flush_out_valid", a_out_valid, 0);
      chk("flush_r", a_r, 0);
      repeat (8) @(posedge clk);
      #1;
      send_a({32'h00000000, 32'h00030000, 32'hFFFF0000},
             {32'h00000000, 32'h00010000, 32'h00050000}, MODE_LANEWISE);
      wait_lat(lat);
      chk("post_rst_latency", lat, LAT);
      chk("post_rst_r", a_r, {32'h00000000, 32'h00030000, 32'hFFFB0000});
      @(posedge clk); #1;

      // random beats on the Q16.16 instance with random consumer stalls
      @(negedge clk) ready_mode = 1;
      @(posedge clk); #1;
      for (int k = 0; k < 300; k++) send_a(rnd96(), rnd96(), logic'($urandom_range(0, 1)));
      @(negedge clk) ready_mode = 0;
      drain(1'b0);

      // 4-lane Q8.8 sweep
      @(negedge clk) ready_mode = 1;
      @(posedge clk); #1;
      base = b_rx;
      for (int k = 0; k < 10000; k++) begin
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk); #1;
         end
         send_b({$urandom, $urandom}, {$urandom, $urandom}, logic'($urandom_range(0, 1)));
      end
      @(negedge clk) ready_mode = 0;
      drain(1'b1);
      chk("b_result_count", b_rx - base, 10000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
